// File: rtl/ifetch_pkg.sv
// ============================================================================
// ifetch_pkg : shared types and constants for the instruction-fetch block
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] HALT_OPCODE_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_buffer.sv
// ============================================================================
// ifetch_buffer : BUF_DEPTH-entry FIFO of {pc, instr}; push-on-full allowed
//                 when a pop happens on the same edge; flush wins over both.
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module ifetch_buffer
  import ifetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         empty,
  output logic         full,
  output fetch_entry_t head
);

  localparam int                 c_ptr_w   = $clog2(BUF_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
  localparam logic [c_ptr_w:0]   c_cnt_one = 1;
  localparam logic [c_ptr_w:0]   c_depth   = BUF_DEPTH[c_ptr_w:0];

  fetch_entry_t         r_mem [BUF_DEPTH];
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w:0]     r_count;
  logic                 w_pop;
  logic                 w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == c_depth);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign head   = r_mem[r_rd_ptr];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// ============================================================================
// instr_fetch_ctrl : PC sequencer feeding a decode FIFO; redirect/flush and
//                    optional halt-opcode stop (macro IFETCH_HALT_DETECT_EN).
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module instr_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC    = 16'h0000,
  parameter int                 BUF_DEPTH   = 2,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic               busy,
  output logic               halted
);

  ifetch_state_e     r_state;
  ifetch_state_e     w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  fetch_entry_t      w_push_data;
  fetch_entry_t      w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_fetch;
  logic              w_halt_match;
  logic              w_is_halt;

  assign dec_valid    = !w_empty;
  assign w_pop        = dec_valid && dec_ready;
  assign w_fetch      = (r_state == RUN) && !redirect_valid && (!w_full || w_pop);
  assign w_halt_match = (imem_instr == HALT_OPCODE);
  assign w_push_data  = '{pc: r_pc, instr: imem_instr};

`ifdef IFETCH_HALT_DETECT_EN
  assign w_is_halt = w_fetch && w_halt_match;
  assign halted    = (r_state == HALTED);
`else
  // Detection compiled out: the halt encoding is just another instruction.
  assign w_is_halt = w_fetch & w_halt_match & 1'b0;
  assign halted    = 1'b0;
`endif

  assign busy      = (r_state == RUN);
  assign imem_addr = r_pc;
  assign dec_instr = w_head.instr;
  assign dec_pc    = w_head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      IDLE:    if (start)          w_state_nxt = RUN;
      RUN:     if (w_is_halt)      w_state_nxt = HALTED;
      HALTED:  if (redirect_valid) w_state_nxt = RUN;
      default:                     w_state_nxt = IDLE;
    endcase
    // The halt word is enqueued but the PC parks on its address.
    if (w_fetch && !w_is_halt) begin
      w_pc_nxt = r_pc + 16'd1;
    end
    if (redirect_valid) begin
      w_pc_nxt = redirect_pc;
    end
  end

  ifetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (w_fetch),
    .push_data (w_push_data),
    .pop       (w_pop),
    .empty     (w_empty),
    .full      (w_full),
    .head      (w_head)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ============================================================================
// tb_instr_fetch_ctrl : scenario tasks plus a randomized run checked against
//                       an in-order delivery model of the fetch stream.
// Rev 1.0             : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_ctrl;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam int          BUF_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic        busy;
  logic        halted;
  logic        halt_word_en;

  int n_cmp;
  int n_bad;

  always #5 clk = ~clk;

  // Memory image: word k = 16'h1000 + k, optionally word 3 = 16'hFFFF.
  assign imem_instr = (halt_word_en && imem_addr == 16'h0003) ? 16'hFFFF
                                                             : 16'h1000 + imem_addr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_word_en && a == 16'h0003) return 16'hFFFF;
    return 16'h1000 + a;
  endfunction

  instr_fetch_ctrl #(
    .RESET_PC    (RESET_PC),
    .BUF_DEPTH   (BUF_DEPTH),
    .HALT_OPCODE (16'hFFFF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .busy           (busy),
    .halted         (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    dec_ready      = 1'b0;
    halt_word_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
    n_cmp++; if (dec_instr !== 16'h0) begin n_bad++; $display("FAIL reset_dec_instr: got %h want 0000", dec_instr); end
    n_cmp++; if (dec_pc !== 16'h0) begin n_bad++; $display("FAIL reset_dec_pc: got %h want 0000", dec_pc); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [15:0] e;
    do_reset();
    dec_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stream_busy: got %b want 1", busy); end
    n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL stream_first_bubble: got %b want 0", dec_valid); end
    step();
    for (int k = 0; k < 4; k++) begin
      e = RESET_PC + 16'(k);
      n_cmp++;
      if (dec_valid !== 1'b1 || dec_pc !== e || dec_instr !== mem_word(e)) begin
        n_bad++;
        $display("FAIL stream_k%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, dec_valid, dec_pc, dec_instr, e, mem_word(e));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      e = (i == 0) ? 16'h0001 : 16'h0002;
      n_cmp++;
      if (imem_addr !== e || dec_valid !== 1'b1 || dec_pc !== 16'h0000 || dec_instr !== 16'h1000) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: got addr=%h v=%b pc=%h ins=%h want addr=%h v=1 pc=0000 ins=1000", i, imem_addr, dec_valid, dec_pc, dec_instr, e);
      end
    end
    dec_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e = 16'(k);
      n_cmp++;
      if (dec_valid !== 1'b1 || dec_pc !== e || dec_instr !== mem_word(e)) begin
        n_bad++;
        $display("FAIL bp_resume_k%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, dec_valid, dec_pc, dec_instr, e, mem_word(e));
      end
      step();
    end
  endtask

  task automatic test_redirect();
    logic [15:0] e;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got v=%b want 0", dec_valid); end
    n_cmp++; if (imem_addr !== 16'h0040) begin n_bad++; $display("FAIL redir_addr: got %h want 0040", imem_addr); end
    step();
    dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = 16'h0040 + 16'(k);
      n_cmp++;
      if (dec_valid !== 1'b1 || dec_pc !== e || dec_instr !== mem_word(e)) begin
        n_bad++;
        $display("FAIL redir_k%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, dec_valid, dec_pc, dec_instr, e, mem_word(e));
      end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || imem_addr !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_idle_load: got busy=%b addr=%h want busy=0 addr=fffe", busy, imem_addr); end
    dec_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      e = 16'hFFFE + 16'(k);
      n_cmp++;
      if (dec_valid !== 1'b1 || dec_pc !== e || dec_instr !== mem_word(e)) begin
        n_bad++;
        $display("FAIL wrap_k%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, dec_valid, dec_pc, dec_instr, e, mem_word(e));
      end
      step();
    end
  endtask

  task automatic test_halt();
    int got;
    do_reset();
    halt_word_en = 1'b1;
    dec_ready    = 1'b1;
    start        = 1'b1;
    step();
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (dec_valid && dec_ready) begin
        n_cmp++;
        if (dec_pc !== 16'(got) || dec_instr !== mem_word(16'(got))) begin
          n_bad++;
          $display("FAIL halt_order_%0d: got pc=%h ins=%h want pc=%h ins=%h", got, dec_pc, dec_instr, 16'(got), mem_word(16'(got)));
        end
        got++;
      end
      step();
    end
`ifdef IFETCH_HALT_DETECT_EN
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL halt_count: got %0d want 4", got); end
    n_cmp++; if (halted !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL halt_state: got halted=%b busy=%b want 1 0", halted, busy); end
    n_cmp++; if (imem_addr !== 16'h0003) begin n_bad++; $display("FAIL halt_addr: got %h want 0003", imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || halted !== 1'b0) begin n_bad++; $display("FAIL halt_restart: got busy=%b halted=%b want 1 0", busy, halted); end
    step();
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0000) begin n_bad++; $display("FAIL halt_refetch: got v=%b pc=%h want v=1 pc=0000", dec_valid, dec_pc); end
`else
    n_cmp++; if (halted !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL nohalt_state: got halted=%b busy=%b want 0 1", halted, busy); end
    n_cmp++; if (got < 5) begin n_bad++; $display("FAIL nohalt_word4: got %0d delivered want at least 5", got); end
`endif
  endtask

  // Model: delivered PCs form an unbroken +1 sequence from the last start or
  // redirect target; the FIFO holds exactly the PCs in [exp_next, imem_addr).
  task automatic test_random();
    logic [15:0] exp_next;
    logic [15:0] occ;
    logic        rd;
    int          delivered;
    do_reset();
    start = 1'b1;
    step();
    start     = 1'b0;
    exp_next  = RESET_PC;
    delivered = 0;
    for (int c = 0; c < 600; c++) begin
      dec_ready      = ($urandom_range(0, 3) != 0);
      rd             = ($urandom_range(0, 24) == 0);
      redirect_valid = rd;
      redirect_pc    = 16'($urandom_range(0, 16'h0EFF));
      occ = imem_addr - exp_next;
      n_cmp++;
      if (occ > 16'(BUF_DEPTH) || dec_valid !== (occ != 16'h0)) begin
        n_bad++;
        $display("FAIL rand_occ_c%0d: got v=%b addr=%h want next=%h occ<=%0d", c, dec_valid, imem_addr, exp_next, BUF_DEPTH);
      end
      if (dec_valid && dec_ready) begin
        n_cmp++;
        if (dec_pc !== exp_next || dec_instr !== mem_word(exp_next)) begin
          n_bad++;
          $display("FAIL rand_deliver_c%0d: got pc=%h ins=%h want pc=%h ins=%h", c, dec_pc, dec_instr, exp_next, mem_word(exp_next));
        end
        exp_next  = exp_next + 16'd1;
        delivered++;
      end
      if (rd) exp_next = redirect_pc;
      step();
    end
    redirect_valid = 1'b0;
    n_cmp++; if (delivered < 200) begin n_bad++; $display("FAIL rand_progress: got %0d delivered want at least 200", delivered); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    n_cmp++; if (dec_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL arst_pre: got v=%b busy=%b want 1 1", dec_valid, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dec_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || imem_addr !== RESET_PC || dec_pc !== 16'h0) begin
      n_bad++;
      $display("FAIL arst_clear: got v=%b busy=%b halted=%b addr=%h pc=%h want 0 0 0 %h 0000", dec_valid, busy, halted, imem_addr, dec_pc, RESET_PC);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the combinational instruction memory (16-bit address in, 16-bit instruction out, same-cycle read). Each fetched instruction, tagged with its PC, enters a small FIFO and is presented to the decode stage over a valid/ready handshake. The block supports start, branch/jump redirect with flush, and an optional halt opcode. It sits between the instruction memory and the decoder.

## Interface
One clock; reset is asynchronous and active-low.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- BUF_DEPTH, 2, FIFO entries; power of two, at least 2.
- HALT_OPCODE, 16'hFFFF, halt encoding; used only with IFETCH_HALT_DETECT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE.
- redirect_valid  in  1  load new PC and flush.
- redirect_pc  in  16  redirect target.
- imem_addr  out  16  address to instruction memory; equals the PC register.
- imem_instr  in  16  instruction read combinationally at imem_addr.
- dec_valid  out  1  FIFO head is valid.
- dec_ready  in  1  decoder accepts the head.
- dec_instr  out  16  head instruction.
- dec_pc  out  16  PC of the head instruction.
- busy  out  1  state is RUN.
- halted  out  1  state is HALTED.

## Operation
- Reset values:
  - State IDLE; PC = RESET_PC; FIFO empty with all entries zeroed.
  - dec_valid = 0, dec_instr = 0, dec_pc = 0, busy = 0, halted = 0.
  - imem_addr = RESET_PC.
- FSM states and transitions:
  - IDLE: start → RUN. redirect_valid loads the PC and stays in IDLE.
  - RUN: halt detected → HALTED (macro only).
  - HALTED: redirect_valid → RUN with the PC loaded. start is ignored.
  - start is ignored outside IDLE.
- Fetch (RUN only):
  - A fetch occurs on an edge when the FIFO has space, or is full and pops on the same edge.
  - Fetch action: enqueue {PC, imem_instr}, then PC ← PC + 1.
  - The PC wraps 16'hFFFF → 16'h0000 with no flag.
- Pop: occurs on an edge when dec_valid && dec_ready.
  - Head outputs hold stable while dec_valid && !dec_ready.
- Redirect has the highest priority and applies in any state:
  - PC ← redirect_pc.
  - FIFO is flushed (count = 0).
  - No enqueue that edge.
  - A pop handshake in the same cycle is counted as consumed.
  - start coincident with redirect in IDLE: the PC loads redirect_pc and the state goes to RUN.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

## Timing
- start sampled at edge N:
  - RUN after N.
  - Instruction at RESET_PC enqueued at edge N+1.
  - dec_valid high after N+1.
- Steady-state throughput with dec_ready held high: one instruction per cycle, no bubbles.
- Redirect sampled at edge R:
  - dec_valid low after R.
  - Target instruction enqueued at R+1 and visible after R+1 (one bubble).
- Backpressure:
  - With dec_ready low, at most BUF_DEPTH instructions are enqueued, then the PC freezes.
  - Fetch resumes on the edge the first pop occurs.
- imem_addr changes only on clock edges, because it is driven directly from the PC register.

## Configuration
- IFETCH_HALT_DETECT_EN defined:
  - A fetched imem_instr == HALT_OPCODE is still enqueued.
  - The PC does not increment; it stays at the halt address.
  - State → HALTED.
  - The FIFO drains normally; only redirect_valid restarts fetch.
- IFETCH_HALT_DETECT_EN undefined:
  - HALTED is unreachable and halted is tied 0.
  - HALT_OPCODE is fetched as an ordinary instruction.

## Structure
- Package ifetch_pkg holds:
  - the FSM state enum (IDLE, RUN, HALTED);
  - ADDR_W = 16 and INSTR_W = 16 constants;
  - the default HALT_OPCODE;
  - the FIFO entry struct {pc, instr}.
- One sub-module, ifetch_buffer:
  - synchronous FIFO with BUF_DEPTH entries;
  - push and pop, with push permitted on a full FIFO when a pop occurs the same edge;
  - synchronous flush;
  - async active-low reset.
- The top level holds the FSM, PC register and fetch/redirect priority logic.

## Test plan
- Reset then start, dec_ready = 1, memory word k = 16'h1000 + k → dec_pc 0, 1, 2, 3 on consecutive cycles, with dec_instr 16'h1000..16'h1003.
- dec_ready = 0 for 5 cycles after start → exactly 2 entries held; imem_addr frozen at 16'h0002; dec_pc/dec_instr stable. Raise dec_ready → in-order delivery resumes with no loss or duplication.
- Redirect to 16'h0040 while FIFO is full → dec_valid low the next cycle, then dec_pc = 16'h0040 one cycle later; the stale entries are never delivered.
- redirect_pc = 16'hFFFE, then run → dec_pc sequence FFFE, FFFF, 0000, 0001.
- With IFETCH_HALT_DETECT_EN and word 3 = 16'hFFFF → words 0–3 delivered, halted = 1, imem_addr stays 16'h0003. Redirect to 16'h0000 → busy = 1 and fetch restarts. Without the macro, the same stimulus gives halted = 0 and word 4 is delivered.
- Assert rst_n mid-stream with dec_valid = 1 → dec_valid, busy and halted go to 0 and imem_addr = RESET_PC before the next clock edge.
